// File: rtl/clock_pkg.sv
// Shared BCD types, digit limits and helpers for the time-of-day counter slice.
package clock_pkg;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd2_t;

  localparam logic [7:0] SEC_LIMIT    = 8'h59;
  localparam logic [7:0] MIN_LIMIT    = 8'h59;
  localparam logic [7:0] HOUR24_LIMIT = 8'h23;
  localparam logic [7:0] HOUR12_LIMIT = 8'h12;

  // In 12-hour mode the day rolls over when the hour leaves 11, not when it wraps 12->01.
  localparam logic [7:0] HOUR12_DAY_LAST = 8'h11;

  function automatic bcd2_t bcd2_inc(input bcd2_t v);
    bcd2_t r;
    if (v.units == 4'd9) begin
      r.tens  = v.tens + 4'd1;
      r.units = 4'd0;
    end else begin
      r.tens  = v.tens;
      r.units = v.units + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd2_mod_counter.sv
// Two-digit BCD counter that loads wrap_value instead of incrementing past limit.
// The wrap flag is combinational so a chain of these can ripple carries in one cycle.
module bcd2_mod_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       inc,
  input  logic [7:0] limit,
  input  logic [7:0] wrap_value,
  output logic [7:0] value,
  output logic       wrap
);

  assign wrap = inc && (value == limit);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= RESET_VALUE;
    end else if (clear) begin
      value <= 8'h00;
    end else if (inc) begin
      value <= wrap ? wrap_value : bcd2_inc(value);
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// hh:mm:ss BCD time-of-day counter with set mode and minute/day carry pulses.
// Optional alarm comparator is built only when TIME_OF_DAY_ALARM_EN is defined.
module time_of_day_counter
  import clock_pkg::*;
#(
  parameter int         HOUR_MOD = 24,
  parameter logic [7:0] RESET_HH = 8'h00,
  parameter logic [7:0] RESET_MM = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1s,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hour,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       min_carry,
  output logic       day_wrap,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_arm,
  output logic       alarm_hit
);

  localparam bit         IS_12H     = (HOUR_MOD == 12);
  localparam logic [7:0] HOUR_LIMIT = IS_12H ? HOUR12_LIMIT : HOUR24_LIMIT;
  localparam logic [7:0] HOUR_WRAP  = IS_12H ? 8'h01 : 8'h00;

  logic run_tick;
  logic sec_wrap;
  logic min_wrap;
  logic hour_wrap;
  logic min_inc;
  logic hour_inc;
  logic day_wrap_next;

  // In set mode the buttons drive minutes and hours directly and the carry chain is cut.
  assign run_tick = tick_1s & ~set_mode;
  assign min_inc  = set_mode ? inc_min  : sec_wrap;
  assign hour_inc = set_mode ? inc_hour : min_wrap;

  bcd2_mod_counter #(.RESET_VALUE(8'h00)) u_sec (
    .clk        (clk),
    .rst        (rst),
    .clear      (set_mode),
    .inc        (run_tick),
    .limit      (SEC_LIMIT),
    .wrap_value (8'h00),
    .value      (ss),
    .wrap       (sec_wrap)
  );

  bcd2_mod_counter #(.RESET_VALUE(RESET_MM)) u_min (
    .clk        (clk),
    .rst        (rst),
    .clear      (1'b0),
    .inc        (min_inc),
    .limit      (MIN_LIMIT),
    .wrap_value (8'h00),
    .value      (mm),
    .wrap       (min_wrap)
  );

  bcd2_mod_counter #(.RESET_VALUE(RESET_HH)) u_hour (
    .clk        (clk),
    .rst        (rst),
    .clear      (1'b0),
    .inc        (hour_inc),
    .limit      (HOUR_LIMIT),
    .wrap_value (HOUR_WRAP),
    .value      (hh),
    .wrap       (hour_wrap)
  );

  assign day_wrap_next = ~set_mode &
                         (IS_12H ? (hour_inc && (hh == HOUR12_DAY_LAST)) : hour_wrap);

  // Pulses are registered so they line up with the counter value they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      min_carry <= 1'b0;
      day_wrap  <= 1'b0;
    end else begin
      min_carry <= sec_wrap;
      day_wrap  <= day_wrap_next;
    end
  end

`ifdef TIME_OF_DAY_ALARM_EN
  logic [7:0] mm_next;
  logic [7:0] hh_next;
  logic       alarm_match;

  // Only a seconds wrap can land on hh:mm:00, and sec_wrap is already gated to run mode.
  assign mm_next     = min_wrap ? 8'h00 : bcd2_inc(mm);
  assign hh_next     = hour_inc ? (hour_wrap ? HOUR_WRAP : bcd2_inc(hh)) : hh;
  assign alarm_match = sec_wrap && alarm_arm &&
                       (mm_next == alarm_mm) && (hh_next == alarm_hh);

  always_ff @(posedge clk) begin
    if (rst) begin
      alarm_hit <= 1'b0;
    end else begin
      alarm_hit <= alarm_match;
    end
  end
`else
  logic unused_alarm_inputs;

  assign unused_alarm_inputs = ^{alarm_hh, alarm_mm, alarm_arm};
  assign alarm_hit           = 1'b0;
`endif

endmodule

// File: tb/tb_time_of_day_counter.sv
// Scoreboard bench for time_of_day_counter: a 24-hour and a 12-hour instance share stimulus,
// expected states are queued at drive time and a monitor compares them after each edge.
module tb_time_of_day_counter;

  typedef struct {
    string      name;
    bit         use12;
    logic [7:0] hh;
    logic [7:0] mm;
    logic [7:0] ss;
    logic       mc;
    logic       dw;
    logic       ah;
  } exp_t;

`ifdef TIME_OF_DAY_ALARM_EN
  localparam logic ALARM_ON = 1'b1;
`else
  localparam logic ALARM_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1s = 1'b0;
  logic       set_mode = 1'b0;
  logic       inc_min = 1'b0;
  logic       inc_hour = 1'b0;
  logic [7:0] alarm_hh = 8'h07;
  logic [7:0] alarm_mm = 8'h30;
  logic       alarm_arm = 1'b0;
  logic       arm_req = 1'b0;

  logic [7:0] a_hh, a_mm, a_ss, b_hh, b_mm, b_ss;
  logic       a_mc, a_dw, a_ah, b_mc, b_dw, b_ah;

  exp_t pend_q[$];
  exp_t exp_q[$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  time_of_day_counter #(.HOUR_MOD(24), .RESET_HH(8'h00), .RESET_MM(8'h00)) dut24 (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hour(inc_hour),
    .hh(a_hh), .mm(a_mm), .ss(a_ss), .min_carry(a_mc), .day_wrap(a_dw),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm_hit(a_ah)
  );

  time_of_day_counter #(.HOUR_MOD(12), .RESET_HH(8'h12), .RESET_MM(8'h00)) dut12 (
    .clk(clk), .rst(rst), .tick_1s(tick_1s), .set_mode(set_mode),
    .inc_min(inc_min), .inc_hour(inc_hour),
    .hh(b_hh), .mm(b_mm), .ss(b_ss), .min_carry(b_mc), .day_wrap(b_dw),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_arm(alarm_arm), .alarm_hit(b_ah)
  );

  function automatic logic [7:0] bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  // Queue an expectation for the edge that the next applyStimulus call drives.
  task automatic expectState(input string name, input bit use12, input logic [7:0] h,
                             input logic [7:0] m, input logic [7:0] s,
                             input logic mc, input logic dw, input logic ah);
    exp_t e;
    e.name = name; e.use12 = use12; e.hh = h; e.mm = m; e.ss = s;
    e.mc = mc; e.dw = dw; e.ah = ah;
    pend_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic r, input logic t, input logic s,
                               input logic im, input logic ih);
    @(negedge clk);
    rst = r; tick_1s = t; set_mode = s; inc_min = im; inc_hour = ih;
    alarm_arm = arm_req;
    while (pend_q.size() != 0) exp_q.push_back(pend_q.pop_front());
    @(posedge clk);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [7:0] h, m, s;
    logic       mc, dw, ah;
    if (e.use12) begin
      h = b_hh; m = b_mm; s = b_ss; mc = b_mc; dw = b_dw; ah = b_ah;
    end else begin
      h = a_hh; m = a_mm; s = a_ss; mc = a_mc; dw = a_dw; ah = a_ah;
    end
    compared++;
    if ({h, m, s, mc, dw, ah} !== {e.hh, e.mm, e.ss, e.mc, e.dw, e.ah}) begin
      mismatched++;
      $display("[TB] FAIL %s (%0d-hour): got %h:%h:%h mc=%b dw=%b ah=%b, expected %h:%h:%h mc=%b dw=%b ah=%b",
               e.name, e.use12 ? 12 : 24, h, m, s, mc, dw, ah,
               e.hh, e.mm, e.ss, e.mc, e.dw, e.ah);
    end
  endtask

  // Monitor: every expectation queued for an edge is checked just after that edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      while (exp_q.size() != 0) checkOutput(exp_q.pop_front());
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset values for both hour moduli.
    expectState("reset24", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    expectState("reset12", 1, 8'h12, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);

    for (int i = 0; i < 100; i++) begin
      if (i % 25 == 24) expectState("idle_hold", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
    end

    expectState("set_preload", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);

    // 60 ticks: seconds run 01..59 then 00 with exactly one minute carry.
    for (int i = 1; i <= 60; i++) begin
      expectState("sec_run", 0, 8'h00, (i == 60) ? 8'h01 : 8'h00, bcd(i % 60),
                  (i == 60), 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end

    for (int i = 1; i <= 5; i++) applyStimulus(0, 1, 0, 0, 0);
    expectState("set_clears_ss", 0, 8'h00, 8'h01, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);

    expectState("inc_both", 0, 8'h01, 8'h02, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 1, 1, 1);
    for (int i = 0; i < 22; i++) applyStimulus(0, 0, 1, 0, 1);
    for (int i = 0; i < 57; i++) applyStimulus(0, 0, 1, 1, 0);
    expectState("set_tick_ignored", 0, 8'h23, 8'h59, 8'h00, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0);

    for (int i = 1; i <= 59; i++) begin
      expectState("run_to_235959", 0, 8'h23, 8'h59, bcd(i), 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end
    expectState("day_wrap24", 0, 8'h00, 8'h00, 8'h00, 1, 1, 0);
    applyStimulus(0, 1, 0, 0, 0);
    expectState("pulses_drop", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Set mode: minutes wrap modulo 60 without touching hours.
    for (int i = 1; i <= 61; i++) begin
      expectState("inc_min_set", 0, 8'h00, bcd(i % 60), 8'h00, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
    end
    for (int i = 1; i <= 24; i++) begin
      expectState("inc_hour_set", 0, bcd(i % 24), 8'h01, 8'h00, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 1);
    end

    // Mid-count reset coincident with a tick that would have carried.
    for (int i = 0; i < 12; i++) applyStimulus(0, 0, 1, 0, 1);
    for (int i = 0; i < 33; i++) applyStimulus(0, 0, 1, 1, 0);
    for (int i = 1; i <= 59; i++) begin
      if (i == 56 || i == 59) expectState("run_to_1234", 0, 8'h12, 8'h34, bcd(i), 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end
    expectState("reset_mid24", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    expectState("reset_mid12", 1, 8'h12, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    expectState("after_reset", 0, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // 12-hour mode: 12->01 in set mode, then 11:59:59 -> 12:00:00 with day_wrap.
    expectState("hr12_set_wrap", 1, 8'h01, 8'h00, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 1);
    for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0, 1);
    for (int i = 1; i <= 59; i++) begin
      if (i == 59) begin
        expectState("set_1159_12", 1, 8'h11, 8'h59, 8'h00, 0, 0, 0);
        expectState("set_1159_24", 0, 8'h11, 8'h59, 8'h00, 0, 0, 0);
      end
      applyStimulus(0, 0, 1, 1, 0);
    end
    for (int i = 1; i <= 59; i++) begin
      if (i == 59) expectState("run_115959", 1, 8'h11, 8'h59, 8'h59, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end
    expectState("day_wrap12", 1, 8'h12, 8'h00, 8'h00, 1, 1, 0);
    expectState("noon24_no_wrap", 0, 8'h12, 8'h00, 8'h00, 1, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);

    // Alarm at 07:30, armed: set mode passing 07:30 must not fire; run mode must.
    arm_req = 1'b1;
    applyStimulus(1, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) applyStimulus(0, 0, 1, 0, 1);
    for (int i = 1; i <= 30; i++) begin
      if (i == 30) expectState("alarm_set_silent", 0, 8'h07, 8'h30, 8'h00, 0, 0, 0);
      applyStimulus(0, 0, 1, 1, 0);
    end
    for (int i = 0; i < 59; i++) applyStimulus(0, 0, 1, 1, 0);
    for (int i = 1; i <= 58; i++) begin
      if (i == 58) expectState("run_072958", 0, 8'h07, 8'h29, 8'h58, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end
    expectState("alarm_before", 0, 8'h07, 8'h29, 8'h59, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0);
    expectState("alarm_hit", 0, 8'h07, 8'h30, 8'h00, 1, 0, ALARM_ON);
    applyStimulus(0, 1, 0, 0, 0);
    expectState("alarm_after", 0, 8'h07, 8'h30, 8'h00, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0);

    // Disarmed alarm stays quiet when reaching the same time.
    arm_req = 1'b0;
    for (int i = 0; i < 59; i++) applyStimulus(0, 0, 1, 1, 0);
    for (int i = 1; i <= 60; i++) begin
      if (i == 60) expectState("alarm_disarmed", 0, 8'h07, 8'h30, 8'h00, 1, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
    end

    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 0, 0);
    compared++;
    if (exp_q.size() != 0 || pend_q.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0",
               exp_q.size() + pend_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/time_of_day_counter.md
Name: time_of_day_counter

Overview:
- Consumes the 1-cycle one-second tick from the clock divider and maintains the time of day as hh:mm:ss in packed BCD.
- Feeds the display multiplexer.
- Provides a set mode driven by debounced button pulses.
- Emits carry pulses for downstream consumers such as the date and chime logic.

Parameters:
- HOUR_MOD, 24, hour modulus; legal values 24 or 12. In 12 mode hours run 01..12 and reset to 12.
- RESET_HH, 8'h00, BCD hour value loaded on reset. Must be legal for HOUR_MOD.
- RESET_MM, 8'h00, BCD minute value loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- tick_1s  in  1  one-cycle pulse per second from the divider
- set_mode  in  1  level; 1 = time-set mode
- inc_min  in  1  one-cycle pulse; increment minutes while set_mode=1
- inc_hour  in  1  one-cycle pulse; increment hours while set_mode=1
- hh  out  8  hours in BCD ({tens,units})
- mm  out  8  minutes in BCD
- ss  out  8  seconds in BCD
- min_carry  out  1  one-cycle pulse when ss wraps 59->00
- day_wrap  out  1  one-cycle pulse when the time wraps 23:59:59->00:00:00 (24 mode) or 11:59:59->12:00:00 (12 mode)
- alarm_hh  in  8  BCD alarm hour (used only with ALARM_EN)
- alarm_mm  in  8  BCD alarm minute (used only with ALARM_EN)
- alarm_arm  in  1  alarm enable level (used only with ALARM_EN)
- alarm_hit  out  1  one-cycle alarm pulse

Behaviour:
- Clock and reset: all state updates on posedge clk. rst is synchronous and active-high and takes priority over every other input.
- Reset values: hh=RESET_HH, mm=RESET_MM, ss=8'h00; min_carry, day_wrap and alarm_hit = 0.
- Output timing: all outputs are registered. Counter outputs update on the clock edge that samples tick_1s=1, so latency is 1 cycle from tick to new value. Pulse outputs assert in that same cycle and are 0 otherwise.
- BCD digit rules: units count 0..9. Tens increment when units wrap 9->0. Limits are seconds and minutes 00..59 and hours 00..23 (or 01..12). Outputs never hold a non-BCD digit.
- Run mode (set_mode=0), on tick_1s:
  - ss increments.
  - At ss=59: ss->00, min_carry=1, mm increments.
  - At mm=59 with that carry: mm->00 and hh increments.
  - At hh at its limit with that carry: hh wraps and day_wrap=1.
  - inc_min and inc_hour are ignored in run mode.
- Set mode (set_mode=1):
  - tick_1s is ignored and ss is forced to 00 on every cycle.
  - inc_min increments mm modulo 60 with no carry into hh.
  - inc_hour increments hh modulo HOUR_MOD with no day_wrap.
  - Simultaneous inc_min and inc_hour apply both in the same cycle.
  - min_carry and day_wrap are never asserted in set mode.
- Mode changes:
  - Leaving set mode resumes counting from hh:mm:00 on the next tick.
  - A tick coinciding with the 1->0 transition of set_mode is processed as run mode in that cycle.
- Held inputs: tick_1s held high for several cycles advances the count once per cycle. Upstream must guarantee single-cycle pulses.
- Reset mid-count: the count returns to RESET_HH:RESET_MM:00 on the next edge. Any pending pulse is cleared.

Optional Feature:
- Macro: TIME_OF_DAY_ALARM_EN.
- With the macro defined: alarm_hit=1 for one cycle when a run-mode tick moves the time to alarm_hh:alarm_mm:00 and alarm_arm=1. Setting the time in set mode never fires the alarm.
- Without the macro: alarm_hit is tied to 0, alarm_hh, alarm_mm and alarm_arm are unused, and no alarm comparator logic exists. The port list is identical in both builds.

Decomposition:
- Package clock_pkg:
  - typedef bcd2_t as a packed 8-bit {tens[3:0], units[3:0]}.
  - Constants SEC_LIMIT=8'h59, MIN_LIMIT=8'h59, HOUR24_LIMIT=8'h23, HOUR12_LIMIT=8'h12.
- Sub-module bcd2_mod_counter, instantiated three times:
  - Two-digit BCD counter with inc, synchronous clear/load, and limit/wrap value inputs.
  - Outputs the value and a combinational wrap flag asserted when inc=1 and value=limit.

Test Plan:
- Reset with RESET_HH=8'h00 -> hh/mm/ss = 00:00:00 and all pulses 0. Hold tick_1s=0 for 100 cycles -> no change.
- Preload via set mode to 00:00:00, then apply 60 ticks -> ss 00..59 then 00. min_carry pulses exactly once on the 60th tick; mm=01.
- Set to 23:59, leave set mode, apply 59 ticks -> 23:59:59. The next tick -> 00:00:00 with min_carry=1 and day_wrap=1 in the same cycle.
- Set mode: inc_min pulsed 61 times from mm=00 -> mm=01, hh unchanged. Assert inc_hour and inc_min together -> both advance. Ticks during set mode leave ss=00.
- Mid-count reset: at 12:34:56, assert rst for 1 cycle coincident with tick_1s -> 00:00:00 and no min_carry. With HOUR_MOD=12 and 11:59:59, a tick -> 12:00:00 with day_wrap=1.
- With TIME_OF_DAY_ALARM_EN: alarm 07:30 armed, run from 07:29:58 -> alarm_hit on the tick reaching 07:30:00 only. With alarm_arm=0 or the macro undefined, alarm_hit stays 0.
